bldc_hall_filter: RTL and testbench

Conditions raw BLDC hall-sensor inputs before they reach the hall step counter and commutation logic. It synchronises the three hall lines into the clock domain and rejects glitches shorter than a programmable stability window. It validates each accepted state against the 6-step sequence and reports the accepted step, its direction, and any fault. Its clean hall_out and hall_step outputs are what the downstream hall counter consumes.

---
 rtl/bldc_hall_filter.sv | 150 +++++++++++++++
 tb/tb_bldc_hall_filter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_hall_filter.sv
// Hall-sensor front end for a BLDC drive: synchronises the three hall lines, rejects
// short glitches, and checks each accepted state against the 6-step commutation sequence.
module bldc_hall_filter #(
    parameter int FILTER_CYCLES   = 16,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 hall_raw,
    input  logic                       fault_clear,
    output logic [2:0]                 hall_out,
    output logic                       hall_valid,
    output logic                       hall_step,
    output logic                       dir,
    output logic                       illegal_state,
    output logic                       skip_err,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    localparam int CNT_W = $clog2(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       sync_meta;
    logic [2:0]       sync;
    logic [2:0]       candidate;
    logic [CNT_W-1:0] stab_cnt;

    // Position of a legal hall code in the forward sequence 101,100,110,010,011,001.
    function automatic logic [2:0] step_pos(input logic [2:0] h);
        case (h)
            3'b101:  step_pos = 3'd0;
            3'b100:  step_pos = 3'd1;
            3'b110:  step_pos = 3'd2;
            3'b010:  step_pos = 3'd3;
            3'b011:  step_pos = 3'd4;
            3'b001:  step_pos = 3'd5;
            default: step_pos = 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta <= '0;
            sync      <= '0;
            candidate <= '0;
            stab_cnt  <= '0;
        end else begin
            sync_meta <= hall_raw;
            sync      <= sync_meta;
            if (sync != candidate) begin
                candidate <= sync;
                stab_cnt  <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    logic       accept;
    logic       cand_legal;
    logic [2:0] pos_old;
    logic [2:0] pos_new;
    logic [3:0] pos_sum;
    logic [2:0] fwd_dist;
    logic       is_same;
    logic       is_fwd;
    logic       is_rev;

    // fwd_dist is how many forward steps separate hall_out from the candidate (0..5).
    always_comb begin
        accept     = (sync == candidate) && (stab_cnt == CNT_MAX);
        cand_legal = (candidate != 3'b000) && (candidate != 3'b111);
        pos_old    = step_pos(hall_out);
        pos_new    = step_pos(candidate);
        pos_sum    = 4'(pos_new) + 4'd6 - 4'(pos_old);
        fwd_dist   = (pos_sum >= 4'd6) ? 3'(pos_sum - 4'd6) : 3'(pos_sum);
        is_same    = (fwd_dist == 3'd0);
        is_fwd     = (fwd_dist == 3'd1);
        is_rev     = (fwd_dist == 3'd5);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_INIT;
            hall_out      <= '0;
            hall_valid    <= 1'b0;
            hall_step     <= 1'b0;
            dir           <= 1'b0;
            illegal_state <= 1'b0;
            skip_err      <= 1'b0;
            err_count     <= '0;
        end else begin
            hall_step <= 1'b0;
            skip_err  <= 1'b0;
            if (fault_clear) begin
                err_count <= '0;
            end
            case (state)
                ST_INIT: begin
                    if (accept && !cand_legal) begin
                        state         <= ST_FAULT;
                        illegal_state <= 1'b1;
                        hall_valid    <= 1'b0;
                    end else if (accept) begin
                        state      <= ST_RUN;
                        hall_out   <= candidate;
                        hall_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept && !cand_legal) begin
                        state         <= ST_FAULT;
                        illegal_state <= 1'b1;
                        hall_valid    <= 1'b0;
                    end else if (accept && !is_same) begin
                        hall_out <= candidate;
                        if (is_fwd || is_rev) begin
                            hall_step <= 1'b1;
                            dir       <= is_fwd;
                        end else begin
                            skip_err <= 1'b1;
                            // A simultaneous clear takes precedence over the count.
                            if (!fault_clear && (err_count != '1)) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clear && accept && cand_legal) begin
                        state         <= ST_INIT;
                        illegal_state <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_INIT;
                    hall_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bldc_hall_filter.sv
// Bench for bldc_hall_filter: directed table rows, hand sequences for timing corners,
// and randomized hall activity compared cycle by cycle against a sequence-level model.
module tb_bldc_hall_filter;

    localparam int F  = 4;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    hall_raw = 3'b000;
    logic          fault_clear = 1'b0;
    logic [2:0]    hall_out;
    logic          hall_valid;
    logic          hall_step;
    logic          dir;
    logic          illegal_state;
    logic          skip_err;
    logic [EW-1:0] err_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    bldc_hall_filter #(
        .FILTER_CYCLES(F),
        .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hall_raw(hall_raw),
        .fault_clear(fault_clear),
        .hall_out(hall_out),
        .hall_valid(hall_valid),
        .hall_step(hall_step),
        .dir(dir),
        .illegal_state(illegal_state),
        .skip_err(skip_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: the hall value the synchroniser presents is the raw input from two
    // edges earlier; a value is accepted once it has been presented F+1 edges in a row.
    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [2:0] hist [$];
    logic [2:0] last_seen;
    int         run_len;
    int         m_state;
    logic [2:0] m_out;
    logic       m_valid, m_step, m_dir, m_ill, m_skip;
    logic [EW-1:0] m_err;

    function automatic int idx_of(input logic [2:0] h);
        for (int i = 0; i < 6; i++) if (seq[i] == h) return i;
        return -1;
    endfunction

    task automatic model_edge();
        logic [2:0] seen;
        int in_i, old_i, d;
        m_step = 1'b0;
        m_skip = 1'b0;
        if (!reset) begin
            m_out = 3'b000; m_valid = 1'b0; m_dir = 1'b0; m_ill = 1'b0; m_err = '0;
            m_state = 0;
            hist.delete();
            repeat (3) hist.push_back(3'b000);
            run_len = 1;
            last_seen = 3'b000;
            return;
        end
        hist.push_front(hall_raw);
        seen = hist[2];
        void'(hist.pop_back());
        if (seen == last_seen) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_len = 1;
        end
        last_seen = seen;
        if (fault_clear) m_err = '0;
        if (run_len < F + 1) return;
        in_i = idx_of(seen);
        case (m_state)
            0: begin
                if (in_i < 0) begin
                    m_state = 2; m_ill = 1'b1; m_valid = 1'b0;
                end else begin
                    m_state = 1; m_out = seen; m_valid = 1'b1;
                end
            end
            1: begin
                if (in_i < 0) begin
                    m_state = 2; m_ill = 1'b1; m_valid = 1'b0;
                end else begin
                    old_i = idx_of(m_out);
                    d = (in_i - old_i + 6) % 6;
                    if (d == 1) begin
                        m_out = seen; m_step = 1'b1; m_dir = 1'b1;
                    end else if (d == 5) begin
                        m_out = seen; m_step = 1'b1; m_dir = 1'b0;
                    end else if (d != 0) begin
                        m_out = seen; m_skip = 1'b1;
                        if (!fault_clear && m_err != '1) m_err = m_err + 1'b1;
                    end
                end
            end
            default: begin
                if (in_i >= 0 && fault_clear) begin
                    m_state = 0; m_ill = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {hall_out, hall_valid, hall_step, dir, illegal_state, skip_err, err_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("model", 32'(dut_vec()),
              32'({m_out, m_valid, m_step, m_dir, m_ill, m_skip, m_err}));
    endtask

    typedef struct {
        logic [2:0]    raw;
        logic          fc;
        int            hold;
        logic [2:0]    e_out;
        logic          e_valid;
        logic          e_dir;
        logic          e_ill;
        logic [EW-1:0] e_err;
        int            e_steps;
        int            e_skips;
    } row_t;

    row_t rows [16];

    initial begin
        int steps, skips, pick, cur;
        rows[0]  = '{3'b101, 1'b0, 13, 3'b101, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0};
        rows[1]  = '{3'b100, 1'b0, 20, 3'b100, 1'b1, 1'b1, 1'b0, 3'd0, 1, 0};
        rows[2]  = '{3'b110, 1'b0, 20, 3'b110, 1'b1, 1'b1, 1'b0, 3'd0, 1, 0};
        rows[3]  = '{3'b010, 1'b0,  3, 3'b110, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0};
        rows[4]  = '{3'b110, 1'b0, 20, 3'b110, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0};
        rows[5]  = '{3'b010, 1'b0,  5, 3'b110, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0};
        rows[6]  = '{3'b110, 1'b0, 20, 3'b110, 1'b1, 1'b0, 1'b0, 3'd0, 2, 0};
        rows[7]  = '{3'b100, 1'b0, 20, 3'b100, 1'b1, 1'b0, 1'b0, 3'd0, 1, 0};
        rows[8]  = '{3'b011, 1'b0, 20, 3'b011, 1'b1, 1'b0, 1'b0, 3'd1, 0, 1};
        rows[9]  = '{3'b111, 1'b0, 10, 3'b011, 1'b0, 1'b0, 1'b1, 3'd1, 0, 0};
        rows[10] = '{3'b111, 1'b1,  1, 3'b011, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0};
        rows[11] = '{3'b111, 1'b0,  3, 3'b011, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0};
        rows[12] = '{3'b001, 1'b0, 10, 3'b011, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0};
        rows[13] = '{3'b001, 1'b1,  1, 3'b011, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0};
        rows[14] = '{3'b001, 1'b0,  1, 3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0};
        rows[15] = '{3'b001, 1'b0,  5, 3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0};

        // Reset with a legal value already on the lines.
        reset = 1'b0;
        hall_raw = 3'b101;
        repeat (3) tick();
        check("reset_outputs", 32'(dut_vec()), 32'(0));

        // First acceptance lands exactly F+3 edges after release.
        reset = 1'b1;
        repeat (6) tick();
        check("init_before_latency", 32'(dut_vec()), 32'(0));
        tick();
        check("init_accept", 32'(dut_vec()), 32'(11'b101_1_0_0_0_0_000));

        foreach (rows[i]) begin
            hall_raw = rows[i].raw;
            fault_clear = rows[i].fc;
            steps = 0;
            skips = 0;
            for (int c = 0; c < rows[i].hold; c++) begin
                tick();
                fault_clear = 1'b0;
                steps += int'(hall_step);
                skips += int'(skip_err);
            end
            check($sformatf("row%0d_outputs", i),
                  32'({hall_out, hall_valid, dir, illegal_state, err_count}),
                  32'({rows[i].e_out, rows[i].e_valid, rows[i].e_dir, rows[i].e_ill, rows[i].e_err}));
            check($sformatf("row%0d_steps", i), 32'(steps), 32'(rows[i].e_steps));
            check($sformatf("row%0d_skips", i), 32'(skips), 32'(rows[i].e_skips));
        end

        // Skip coinciding with fault_clear: the clear wins.
        hall_raw = 3'b100;
        repeat (20) tick();
        check("skip_count_one", 32'(err_count), 32'(1));
        hall_raw = 3'b011;
        repeat (6) tick();
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("skip_with_clear", 32'(dut_vec()), 32'(11'b011_1_0_0_0_1_000));
        repeat (13) tick();

        // Nine consecutive skips saturate a 3-bit counter at 7.
        for (int k = 0; k < 9; k++) begin
            hall_raw = (k % 2 == 0) ? 3'b101 : 3'b110;
            repeat (12) tick();
        end
        check("err_saturate", 32'({hall_out, hall_valid, err_count}), 32'({3'b101, 1'b1, 3'd7}));

        // Reset while a new value is two cycles into its stability window.
        hall_raw = 3'b100;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("midfilter_reset", 32'(dut_vec()), 32'(0));
        reset = 1'b1;
        repeat (6) tick();
        check("pending_dropped", 32'(dut_vec()), 32'(0));
        tick();
        check("fresh_accept", 32'(dut_vec()), 32'(11'b100_1_0_0_0_0_000));

        // Randomized hall activity, biased toward legal single steps.
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            cur = idx_of(m_out);
            if (cur >= 0 && pick < 4) hall_raw = seq[(cur + 1) % 6];
            else if (cur >= 0 && pick < 7) hall_raw = seq[(cur + 5) % 6];
            else hall_raw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) reset = 1'b0;
            for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
                fault_clear = ($urandom_range(0, 9) == 0);
                tick();
                reset = 1'b1;
            end
            fault_clear = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
